// File: rtl/div_frac_pkg.sv
// div_frac_pkg: shared state encoding and saturation constants for div_frac_ctrl.
// Revision 1.0
`default_nettype none

package div_frac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Saturation patterns are built 64 bits wide and truncated to DATA_W by the user.
  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] sat_ones(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_frac_ctrl.sv
// div_frac_ctrl: issue/collect controller for div_subshift_frac with divide-by-zero bypass.
// Revision 1.0 -- optional watchdog enabled by defining DIV_FRAC_TIMEOUT_EN.
`default_nettype none

module div_frac_ctrl
  import div_frac_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  output logic              div_en,
  output logic              div_sign,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quotient,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quotient,
  output logic              out_dbz,
  output logic              out_timeout,
  output logic              busy
);

  localparam logic [DATA_W-1:0] SAT_ONES = DATA_W'(sat_ones(DATA_W));
  localparam logic [DATA_W-1:0] SAT_POS  = DATA_W'(sat_pos(DATA_W));
  localparam logic [DATA_W-1:0] SAT_NEG  = DATA_W'(sat_neg(DATA_W));

  state_t state;
  logic   first_wait;

`ifdef DIV_FRAC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign out_timeout        = 1'b0;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      first_wait   <= 1'b0;
      div_en       <= 1'b0;
      div_sign     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_valid    <= 1'b0;
      out_quotient <= '0;
      out_dbz      <= 1'b0;
`ifdef DIV_FRAC_TIMEOUT_EN
      out_timeout  <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_sign     <= in_sign;
            div_dividend <= in_dividend;
            div_divisor  <= in_divisor;
`ifdef DIV_FRAC_TIMEOUT_EN
            out_timeout  <= 1'b0;
            wd_cnt       <= '0;
`endif
            if (in_divisor != '0) begin
              state      <= WAIT;
              div_en     <= 1'b1;
              first_wait <= 1'b1;
              out_dbz    <= 1'b0;
            end else begin
              // Zero divisor never reaches the divider; answer with the saturated value.
              state     <= OUT;
              out_valid <= 1'b1;
              out_dbz   <= 1'b1;
              if (!in_sign)
                out_quotient <= SAT_ONES;
              else if (in_dividend[DATA_W-1])
                out_quotient <= SAT_NEG;
              else
                out_quotient <= SAT_POS;
            end
          end
        end

        WAIT: begin
          first_wait <= 1'b0;
`ifdef DIV_FRAC_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
          // A done seen on the first WAIT cycle may be left over from the previous op.
          if (!first_wait && div_done) begin
            out_quotient <= div_quotient;
            div_en       <= 1'b0;
            out_valid    <= 1'b1;
            state        <= OUT;
          end
`ifdef DIV_FRAC_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT)) begin
            out_quotient <= '0;
            out_timeout  <= 1'b1;
            div_en       <= 1'b0;
            out_valid    <= 1'b1;
            state        <= OUT;
          end
`endif
        end

        OUT: begin
          div_en <= 1'b0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          div_en    <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_frac_ctrl.sv
// tb_div_frac_ctrl: self-checking bench for div_frac_ctrl with a behavioural divider stub.
// Revision 1.0
`default_nettype none

module tb_div_frac_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sign = 1'b0;
  logic [W-1:0] in_dividend = '0;
  logic [W-1:0] in_divisor = '0;
  logic         div_en;
  logic         div_sign;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic         div_done;
  logic [W-1:0] div_quotient;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_quotient;
  logic         out_dbz;
  logic         out_timeout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Divider stub: done rises on the 17th cycle after en rises.
  int           scnt = 0;
  logic         stale_mode = 1'b0;
  logic         nodone_mode = 1'b0;
  logic [W-1:0] stub_q = 16'h1234;

  always @(posedge clk) begin
    if (!div_en) scnt <= 0;
    else         scnt <= scnt + 1;
  end

  assign div_done = nodone_mode ? 1'b0 :
                    stale_mode  ? ((scnt == 0) || (div_en && scnt >= 17)) :
                                  (div_en && scnt >= 17);
  assign div_quotient = stub_q;

  always #5 clk = ~clk;

  div_frac_ctrl #(.DATA_W(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_en(div_en), .div_sign(div_sign),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_dbz(out_dbz),
    .out_timeout(out_timeout), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the saturated divide-by-zero answer.
  function automatic logic [W-1:0] model_sat(input logic sgn, input logic [W-1:0] dvd);
    if (!sgn) return (1 << W) - 1;
    if ($signed(dvd) < 0) return -(1 << (W - 1));
    return (1 << (W - 1)) - 1;
  endfunction

  // Issues one operand triple and collects the result; latency counts cycles after the accept edge.
  task automatic run_op(input logic sgn, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input int hold, output int lat, output int enh,
                        output logic [W-1:0] q, output logic dbz, output logic tmo,
                        output logic stable, output logic seen);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin step(); guard++; end
    in_valid = 1'b1; in_sign = sgn; in_dividend = dvd; in_divisor = dvs;
    step();
    in_valid = 1'b0;
    lat = 1; enh = 0; stable = 1'b1;
    while (!out_valid && lat < 200) begin
      if (div_en) begin
        enh++;
        if (div_dividend !== dvd || div_divisor !== dvs || div_sign !== sgn) stable = 1'b0;
      end
      step();
      lat++;
    end
    seen = out_valid;
    q = out_quotient; dbz = out_dbz; tmo = out_timeout;
    for (int i = 0; i < hold; i++) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if ({div_en, out_valid, out_dbz, out_timeout, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {div_en, out_valid, out_dbz, out_timeout, busy});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if ({div_sign, div_dividend, div_divisor, out_quotient} !== '0) begin
      bad++; $display("FAIL reset_regs: got %h %h %h %h want 0", div_sign, div_dividend, div_divisor, out_quotient);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    int lat, enh; logic [W-1:0] q; logic dbz, tmo, st, seen;
    run_op(1'b0, 16'h4000, 16'h8000, 0, lat, enh, q, dbz, tmo, st, seen);
    total++; if (lat !== 19) begin bad++; $display("FAIL unsigned_latency: got %0d want 19", lat); end
    total++; if (q !== 16'h1234) begin bad++; $display("FAIL unsigned_quotient: got %h want 1234", q); end
    total++; if (dbz !== 1'b0 || tmo !== 1'b0) begin bad++; $display("FAIL unsigned_flags: got dbz=%b tmo=%b want 0 0", dbz, tmo); end
    // en spans accept+1 through the done cycle at accept+18.
    total++; if (enh !== 18) begin bad++; $display("FAIL unsigned_en_cycles: got %0d want 18", enh); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL unsigned_operands_stable: got %b want 1", st); end
  endtask

  task automatic test_dbz();
    int lat, enh; logic [W-1:0] q; logic dbz, tmo, st, seen;
    run_op(1'b1, -16'sd5, 16'h0000, 0, lat, enh, q, dbz, tmo, st, seen);
    total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    total++; if (q !== 16'h8000) begin bad++; $display("FAIL dbz_signed_neg: got %h want 8000", q); end
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", dbz); end
    total++; if (enh !== 0 || div_en !== 1'b0) begin bad++; $display("FAIL dbz_en: got %0d want 0", enh); end
    run_op(1'b0, 16'd7, 16'h0000, 0, lat, enh, q, dbz, tmo, st, seen);
    total++; if (q !== 16'hFFFF) begin bad++; $display("FAIL dbz_unsigned: got %h want ffff", q); end
    run_op(1'b1, 16'd5, 16'h0000, 0, lat, enh, q, dbz, tmo, st, seen);
    total++; if (q !== 16'h7FFF) begin bad++; $display("FAIL dbz_signed_pos: got %h want 7fff", q); end
  endtask

  task automatic test_back_to_back();
    int guard; logic [W-1:0] q0; logic err;
    guard = 0;
    while (!in_ready && guard < 200) begin step(); guard++; end
    in_valid = 1'b1; in_sign = 1'b0; in_dividend = 16'h0100; in_divisor = 16'h0200;
    step();
    in_dividend = 16'h0aaa; in_divisor = 16'h0bbb;
    guard = 0;
    while (!out_valid && guard < 200) begin step(); guard++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_result: got %b want 1", out_valid); end
    q0 = out_quotient; err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_quotient !== q0 || in_ready !== 1'b0 || div_en !== 1'b0) err = 1'b1;
      step();
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_hold: got unstable=%b want 0", err); end
    total++; if (div_dividend !== 16'h0100) begin bad++; $display("FAIL b2b_no_early_accept: got %h want 0100", div_dividend); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || div_en !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_gap: got ready=%b en=%b valid=%b want 1 0 0", in_ready, div_en, out_valid);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (div_en !== 1'b1 || div_dividend !== 16'h0aaa) begin
      bad++; $display("FAIL b2b_second_accept: got en=%b dvd=%h want 1 0aaa", div_en, div_dividend);
    end
    guard = 0;
    while (!out_valid && guard < 200) begin step(); guard++; end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_stale_done();
    int lat, enh; logic [W-1:0] q; logic dbz, tmo, st, seen;
    stale_mode = 1'b1;
    run_op(1'b1, 16'h1000, 16'h2000, 0, lat, enh, q, dbz, tmo, st, seen);
    stale_mode = 1'b0;
    total++; if (lat !== 19) begin bad++; $display("FAIL stale_done_latency: got %0d want 19", lat); end
  endtask

  task automatic test_reset_mid_wait();
    int guard; int early;
    int lat, enh; logic [W-1:0] q; logic dbz, tmo, st, seen;
    guard = 0;
    while (!in_ready && guard < 200) begin step(); guard++; end
    in_valid = 1'b1; in_sign = 1'b0; in_dividend = 16'h0123; in_divisor = 16'h0456;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (div_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL midwait_reset: got en=%b busy=%b valid=%b want 0 0 0", div_en, busy, out_valid);
    end
    early = 0;
    for (int i = 0; i < 30; i++) begin if (out_valid) early++; step(); end
    total++; if (early !== 0) begin bad++; $display("FAIL midwait_discard: got %0d valid cycles want 0", early); end
    run_op(1'b0, 16'h4000, 16'h8000, 0, lat, enh, q, dbz, tmo, st, seen);
    total++;
    if (lat !== 19 || q !== 16'h1234) begin
      bad++; $display("FAIL midwait_recover: got lat=%0d q=%h want 19 1234", lat, q);
    end
  endtask

  task automatic test_random();
    int lat, enh; logic [W-1:0] q; logic dbz, tmo, st, seen;
    logic sgn; logic [W-1:0] dvd, dvs, exp_q;
    for (int n = 0; n < 20; n++) begin
      sgn = 1'($urandom);
      dvd = W'($urandom);
      dvs = ($urandom_range(0, 9) < 3) ? '0 : W'($urandom_range(1, 65535));
      stub_q = W'($urandom);
      exp_q = (dvs == 0) ? model_sat(sgn, dvd) : stub_q;
      run_op(sgn, dvd, dvs, $urandom_range(0, 3), lat, enh, q, dbz, tmo, st, seen);
      total++;
      if (!seen || q !== exp_q || dbz !== (dvs == 0) || lat !== ((dvs == 0) ? 1 : 19) || st !== 1'b1) begin
        bad++;
        $display("FAIL random_op%0d: got q=%h dbz=%b lat=%0d stable=%b want q=%h dbz=%b lat=%0d stable=1",
                 n, q, dbz, lat, st, exp_q, (dvs == 0), (dvs == 0) ? 1 : 19);
      end
    end
    stub_q = 16'h1234;
  endtask

`ifdef DIV_FRAC_TIMEOUT_EN
  task automatic test_timeout();
    int lat, enh; logic [W-1:0] q; logic dbz, tmo, st, seen;
    nodone_mode = 1'b1;
    run_op(1'b0, 16'h1111, 16'h2222, 0, lat, enh, q, dbz, tmo, st, seen);
    nodone_mode = 1'b0;
    total++;
    if (lat !== 10 || tmo !== 1'b1 || q !== '0) begin
      bad++; $display("FAIL timeout: got lat=%0d tmo=%b q=%h want 10 1 0000", lat, tmo, q);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_dbz();
    test_back_to_back();
    test_stale_done();
    test_reset_mid_wait();
    test_random();
`ifdef DIV_FRAC_TIMEOUT_EN
    test_timeout();
`else
    total++;
    if (out_timeout !== 1'b0) begin bad++; $display("FAIL timeout_tied: got %b want 0", out_timeout); end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
